// File: rtl/spi_master_pkg.sv
// Shared types and sizing helpers for the SPI mode-0 master controller.
// Used by spi_master_ctrl and spi_sclk_gen.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

    localparam int SPI_DEFAULT_BITWIDTH = 32;
    localparam int SPI_CNT_W            = $clog2(SPI_DEFAULT_BITWIDTH) + 1;

    // Bit counter / length width: must hold the value BITWIDTH itself.
    function automatic int spi_cnt_w(input int bitwidth);
        return $clog2(bitwidth) + 1;
    endfunction

    // Divider counter width; at least one bit even when CLK_DIV is 1.
    function automatic int spi_div_w(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI master: toggles SCLK every CLK_DIV enabled cycles
// and flags the cycle whose closing clock edge makes SCLK rise or fall.
module spi_sclk_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int               DIV_W    = spi_div_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_tick;

    // The strobes mark the cycle in which the edge is registered, so the
    // controller acts on the same clock edge that moves SCLK.
    assign w_tick       = i_en && (r_div == DIV_LAST);
    assign o_rise_pulse = w_tick && !r_sclk;
    assign o_fall_pulse = w_tick && r_sclk;
    assign o_sclk       = r_sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: loads a word from a val/rdy request, shifts it out MSB
// first while capturing MISO, and returns the reply on a val/rdy response.
// Optional: SPI_MASTER_PKT_LEN_EN adds a per-request pkt_len (bits to transfer).
//
// Handshakes: a transfer on either port happens on the rising clk edge where
// val and rdy are both high; val must then be held until that edge, and data
// is stable while val is high.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_val,
    output logic                       send_rdy,
    input  logic [BITWIDTH-1:0]        send_data,
`ifdef SPI_MASTER_PKT_LEN_EN
    input  logic [$clog2(BITWIDTH):0]  pkt_len,
`endif
    output logic                       recv_val,
    input  logic                       recv_rdy,
    output logic [BITWIDTH-1:0]        recv_data,
    output logic                       spi_sclk,
    output logic                       spi_cs_n,
    output logic                       spi_mosi,
    input  logic                       spi_miso,
    output spi_state_e                 dbg_state
);

    localparam int               CNT_W    = spi_cnt_w(BITWIDTH);
    localparam int               DIV_W    = spi_div_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    spi_state_e          r_state;
    logic                r_send_rdy;
    logic                r_recv_val;
    logic                r_cs_n;
    logic [BITWIDTH-1:0] r_shift;
    logic                r_sample;
    logic [DIV_W-1:0]    r_setup_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;

    logic [BITWIDTH-1:0] w_load_data;
    logic [CNT_W-1:0]    w_last_bit;
    logic                w_sclk_en;
    logic                w_rise;
    logic                w_fall;

`ifdef SPI_MASTER_PKT_LEN_EN
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len;

    // Out-of-range lengths fall back to a full word; the short word is
    // left-aligned so MOSI always comes from the register MSB.
    assign w_len       = (pkt_len == '0 || pkt_len > CNT_W'(BITWIDTH)) ?
                         CNT_W'(BITWIDTH) : pkt_len;
    assign w_load_data = send_data << (CNT_W'(BITWIDTH) - w_len);
    assign w_last_bit  = r_len - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len <= CNT_W'(BITWIDTH);
        end else if (r_state == IDLE && send_val && r_send_rdy) begin
            r_len <= w_len;
        end
    end
`else
    assign w_load_data = send_data;
    assign w_last_bit  = CNT_W'(BITWIDTH - 1);
`endif

    assign w_sclk_en = (r_state == SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (reset),
        .i_en         (w_sclk_en),
        .o_sclk       (spi_sclk),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_send_rdy  <= 1'b1;
            r_recv_val  <= 1'b0;
            r_cs_n      <= 1'b1;
            r_shift     <= '0;
            r_sample    <= 1'b0;
            r_setup_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (send_val && r_send_rdy) begin
                        r_state     <= START;
                        r_send_rdy  <= 1'b0;
                        r_cs_n      <= 1'b0;
                        r_shift     <= w_load_data;
                        r_setup_cnt <= '0;
                        r_bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_setup_cnt == DIV_LAST) begin
                        r_state     <= SHIFT;
                        r_setup_cnt <= '0;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_sample <= spi_miso;
                    end
                    // Shifting on the falling edge moves MOSI to the next bit
                    // and pushes the bit sampled on the preceding rise.
                    if (w_fall) begin
                        r_shift   <= {r_shift[BITWIDTH-2:0], r_sample};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state    <= DONE;
                            r_cs_n     <= 1'b1;
                            r_recv_val <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (recv_rdy) begin
                        r_state    <= IDLE;
                        r_recv_val <= 1'b0;
                        r_send_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign send_rdy  = r_send_rdy;
    assign recv_val  = r_recv_val;
    assign recv_data = r_shift;
    assign spi_cs_n  = r_cs_n;
    assign spi_mosi  = r_shift[BITWIDTH-1];
    assign dbg_state = r_state;

    a_rdy_only_idle : assert property (@(posedge clk) disable iff (!reset)
        r_send_rdy == (r_state == IDLE));
    a_val_only_done : assert property (@(posedge clk) disable iff (!reset)
        r_recv_val == (r_state == DONE));
    a_sclk_needs_cs : assert property (@(posedge clk) disable iff (!reset)
        r_cs_n |-> !spi_sclk);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed scenarios plus random
// transfers against a word-level reference (latency formula, slave model).
module tb_spi_master_ctrl;
    import spi_master_pkg::*;

    localparam int BW     = 8;
    localparam int DIV    = 2;
    localparam int DIV_F  = 1;
    localparam int IW     = $clog2(BW);
    localparam int PL_W   = $clog2(BW) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (CLK_DIV = 2) ----------------
    logic          send_val, send_rdy, recv_val, recv_rdy;
    logic [BW-1:0] send_data, recv_data;
    logic          sclk, cs_n, mosi, miso;
    spi_state_e    dbg_state;
`ifdef SPI_MASTER_PKT_LEN_EN
    logic [PL_W-1:0] pkt_len, f_pkt_len;
`endif

    spi_master_ctrl #(.BITWIDTH(BW), .CLK_DIV(DIV)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_data (send_data),
`ifdef SPI_MASTER_PKT_LEN_EN
        .pkt_len   (pkt_len),
`endif
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_data (recv_data),
        .spi_sclk  (sclk),
        .spi_cs_n  (cs_n),
        .spi_mosi  (mosi),
        .spi_miso  (miso),
        .dbg_state (dbg_state)
    );

    // ---------------- fast DUT (CLK_DIV = 1), MISO looped back ----------------
    logic          f_send_val, f_send_rdy, f_recv_val, f_recv_rdy;
    logic [BW-1:0] f_send_data, f_recv_data;
    logic          f_sclk, f_cs_n, f_mosi;
    spi_state_e    f_dbg_state;

    spi_master_ctrl #(.BITWIDTH(BW), .CLK_DIV(DIV_F)) u_dut_fast (
        .clk       (clk),
        .reset     (reset),
        .send_val  (f_send_val),
        .send_rdy  (f_send_rdy),
        .send_data (f_send_data),
`ifdef SPI_MASTER_PKT_LEN_EN
        .pkt_len   (f_pkt_len),
`endif
        .recv_val  (f_recv_val),
        .recv_rdy  (f_recv_rdy),
        .recv_data (f_recv_data),
        .spi_sclk  (f_sclk),
        .spi_cs_n  (f_cs_n),
        .spi_mosi  (f_mosi),
        .spi_miso  (f_mosi),
        .dbg_state (f_dbg_state)
    );

    // ---------------- SPI slave model and pin monitor ----------------
    logic          loopback = 1'b1;
    logic [BW-1:0] s_reply  = '0;
    int            s_n      = BW;
    int            fall_base = 0;
    int            rises = 0, falls = 0;
    logic          mosi_q[$];
    int            s_pos;
    logic          s_bit;

    // Mode-0 slave: first bit valid once CS falls, next bit after each SCLK fall.
    always_comb begin
        s_pos = s_n - 1 - (falls - fall_base);
        s_bit = (s_pos >= 0 && s_pos < BW) ? s_reply[s_pos[IW-1:0]] : 1'b0;
    end
    assign miso = loopback ? mosi : s_bit;

    always @(posedge sclk) begin
        rises++;
        mosi_q.push_back(mosi);
    end
    always @(negedge sclk) falls++;

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver: one full transfer on the main DUT ----------------
    task automatic do_xfer(input logic [BW-1:0] tx, input logic [BW-1:0] reply,
                           input bit loop, input int len, input int hold);
        int            n, t0, lat_exp, bad_cs, bad_rdy, bad_hold, base_r, base_m;
        logic [BW-1:0] mask, exp_word, got_mosi;

        n = (len <= 0 || len > BW) ? BW : len;
        for (int i = 0; i < BW; i++) mask[i] = (i < n);
        exp_word = (loop ? tx : reply) & mask;
        exp_q.push_back(exp_word);
        lat_exp = 1 + DIV * (2 * n + 1);

        for (int k = 0; k < 200 && send_rdy !== 1'b1; k++) @(negedge clk);
        check_eq("send_rdy_idle", send_rdy, 1);

        loopback  = loop;
        s_reply   = reply;
        s_n       = n;
        fall_base = falls;
        base_r    = rises;
        base_m    = mosi_q.size();
`ifdef SPI_MASTER_PKT_LEN_EN
        pkt_len   = PL_W'(len);
`endif
        send_data = tx;
        send_val  = 1'b1;
        t0        = cyc;
        @(negedge clk);

        bad_cs  = 0;
        bad_rdy = 0;
        for (int k = 0; k < 400 && recv_val !== 1'b1; k++) begin
            if (cs_n !== 1'b0) bad_cs++;
            if (send_rdy !== 1'b0) bad_rdy++;
            send_val  = 1'($urandom_range(0, 1));
            send_data = BW'($urandom);
            recv_rdy  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        send_val = 1'b0;
        recv_rdy = 1'b0;

        check_eq("recv_val_rise", recv_val, 1);
        check_eq("latency", cyc - t0, lat_exp);
        check_eq("cs_low_while_busy", bad_cs, 0);
        check_eq("send_rdy_low_busy", bad_rdy, 0);
        check_eq("cs_high_done", cs_n, 1);
        check_eq("sclk_rises", rises - base_r, n);
        check_eq("recv_data", recv_data, exp_q.pop_front());

        got_mosi = '0;
        for (int k = 0; k < n; k++)
            if (base_m + k < mosi_q.size())
                got_mosi = {got_mosi[BW-2:0], mosi_q[base_m + k]};
        check_eq("mosi_stream", got_mosi, tx & mask);

        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            send_val = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (recv_val !== 1'b1 || recv_data !== exp_word || cs_n !== 1'b1 ||
                send_rdy !== 1'b0 || sclk !== 1'b0) bad_hold++;
        end
        if (hold > 0) check_eq("hold_stable", bad_hold, 0);
        send_val = 1'b0;

        recv_rdy = 1'b1;
        @(negedge clk);
        recv_rdy = 1'b0;
        check_eq("recv_val_after_rdy", recv_val, 0);
        check_eq("send_rdy_after_rdy", send_rdy, 1);
    endtask

    // ---------------- back-to-back on the fast DUT ----------------
    task automatic fast_b2b();
        logic [BW-1:0] w0, w1;
        int            t0, t1, dcyc, lat_f;

        w0 = BW'($urandom);
        w1 = BW'($urandom);
        lat_f = 1 + DIV_F * (2 * BW + 1);
        f_recv_rdy  = 1'b1;
        f_send_data = w0;
        f_send_val  = 1'b1;
        for (int k = 0; k < 50 && f_send_rdy !== 1'b1; k++) @(negedge clk);
        t0 = cyc;
        @(negedge clk);
        f_send_data = w1;

        for (int k = 0; k < 200 && f_recv_val !== 1'b1; k++) @(negedge clk);
        dcyc = cyc;
        check_eq("fast_latency0", dcyc - t0, lat_f);
        check_eq("fast_data0", f_recv_data, w0);
        @(negedge clk);
        check_eq("fast_done_1cycle", f_recv_val, 0);
        check_eq("fast_idle_rdy", f_send_rdy, 1);
        t1 = cyc;
        check_eq("fast_restart_cycle", t1 - dcyc, 1);
        @(negedge clk);
        f_send_val = 1'b0;

        for (int k = 0; k < 200 && f_recv_val !== 1'b1; k++) @(negedge clk);
        check_eq("fast_latency1", cyc - t1, lat_f);
        check_eq("fast_data1", f_recv_data, w1);
        @(negedge clk);
        check_eq("fast_done_1cycle_b", f_recv_val, 0);
        f_recv_rdy = 1'b0;
    endtask

    // ---------------- reset in the middle of a transfer ----------------
    task automatic reset_abort();
        int base_r;

        for (int k = 0; k < 200 && send_rdy !== 1'b1; k++) @(negedge clk);
        loopback  = 1'b1;
        fall_base = falls;
        base_r    = rises;
`ifdef SPI_MASTER_PKT_LEN_EN
        pkt_len   = '0;
`endif
        send_data = 8'hC3;
        send_val  = 1'b1;
        @(negedge clk);
        send_val  = 1'b0;
        for (int k = 0; k < 200 && (rises - base_r) < 4; k++) @(negedge clk);
        check_eq("abort_at_bit4", rises - base_r, 4);

        reset = 1'b0;
        #1;
        check_eq("abort_cs_n", cs_n, 1);
        check_eq("abort_sclk", sclk, 0);
        check_eq("abort_recv_val", recv_val, 0);
        check_eq("abort_send_rdy", send_rdy, 1);
        @(negedge clk);
        check_eq("abort_state", dbg_state, IDLE);
        check_eq("abort_mosi", mosi, 0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        send_val    = 1'b0;
        send_data   = '0;
        recv_rdy    = 1'b0;
        f_send_val  = 1'b0;
        f_send_data = '0;
        f_recv_rdy  = 1'b0;
`ifdef SPI_MASTER_PKT_LEN_EN
        pkt_len     = '0;
        f_pkt_len   = '0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_send_rdy", send_rdy, 1);
        check_eq("rst_recv_val", recv_val, 0);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_recv_data", recv_data, 0);
        check_eq("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        @(negedge clk);

        do_xfer(8'hA5, 8'h00, 1'b1, 0, 0);
        do_xfer(8'hFF, 8'h3C, 1'b0, 0, 0);
        do_xfer(8'h5A, 8'hC6, 1'b0, 0, 10);
        reset_abort();
        do_xfer(8'h81, 8'h00, 1'b1, 0, 0);
        fast_b2b();
`ifdef SPI_MASTER_PKT_LEN_EN
        do_xfer(8'h13, 8'h00, 1'b1, 5, 0);
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef SPI_MASTER_PKT_LEN_EN
            do_xfer(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, BW + 3), $urandom_range(0, 3));
`else
            do_xfer(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)),
                    0, $urandom_range(0, 3));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
